// File: rtl/serial_add_arbiter.sv
// Round-robin sequencer sharing one bit-serial adder among N_REQ requesters.
// Latches the winner's operands, launches the adder and deserialises the LSB-first sum.
module serial_add_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*WIDTH-1:0] req_a_i,
    input  logic [N_REQ*WIDTH-1:0] req_b_i,
    output logic [N_REQ-1:0]       gnt_o,
    output logic [N_REQ-1:0]       rsp_valid_o,
    output logic [WIDTH-1:0]       rsp_sum_o,
    output logic                   rsp_carry_o,
    output logic                   rsp_err_o,
    output logic                   busy_o,
    output logic                   add_start_o,
    output logic [WIDTH-1:0]       add_a_o,
    output logic [WIDTH-1:0]       add_b_o,
    input  logic                   add_sum_bit_i,
    input  logic                   add_carry_i,
    input  logic                   add_done_i
);

    localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StLaunch, StRun, StResp} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [IdxW-1:0]   owner_q, owner_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [WIDTH-1:0]  add_a_q, add_a_d;
    logic [WIDTH-1:0]  add_b_q, add_b_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic              start_q, start_d;
    logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]  rsp_sum_q, rsp_sum_d;
    logic              rsp_carry_q, rsp_carry_d;
    logic              rsp_err_q, rsp_err_d;
    logic              busy_q, busy_d;

    logic              win_found;
    logic [IdxW-1:0]   win_idx;
    logic [IdxW:0]     scan_idx;
    logic [IdxW:0]     ptr_next;
    logic              run_finish;
    logic              run_err;

    // First set request bit at or above ptr_q, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = {1'b0, ptr_q} + (IdxW + 1)'(k);
            if (scan_idx >= (IdxW + 1)'(N_REQ)) begin
                scan_idx = scan_idx - (IdxW + 1)'(N_REQ);
            end
            if (!win_found && req_i[scan_idx[IdxW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_idx[IdxW-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        gnt_d       = '0;
        start_d     = 1'b0;
        rsp_valid_d = '0;
        rsp_sum_d   = '0;
        rsp_carry_d = 1'b0;
        rsp_err_d   = 1'b0;
        run_finish  = 1'b0;
        run_err     = 1'b0;
        ptr_next    = {1'b0, owner_q} + (IdxW + 1)'(1);
        if (ptr_next >= (IdxW + 1)'(N_REQ)) begin
            ptr_next = ptr_next - (IdxW + 1)'(N_REQ);
        end

        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    owner_d        = win_idx;
                    add_a_d        = req_a_i[32'(win_idx) * WIDTH +: WIDTH];
                    add_b_d        = req_b_i[32'(win_idx) * WIDTH +: WIDTH];
                    gnt_d[win_idx] = 1'b1;
                    start_d        = 1'b1;
                    state_d        = StLaunch;
                end
            end
            StLaunch: begin
                cnt_d   = '0;
                state_d = StRun;
            end
            StRun: begin
                sum_d = {add_sum_bit_i, sum_q[WIDTH-1:1]};
                cnt_d = cnt_q + CntW'(1);
                if (add_done_i) begin
                    run_finish = 1'b1;
                    run_err    = ((32'(cnt_q) + 32'd1) != WIDTH);
                end else if (cnt_q == CntW'(TIMEOUT)) begin
                    run_finish = 1'b1;
                    run_err    = 1'b1;
                end
                if (run_finish) begin
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_err_d            = run_err;
                    rsp_sum_d            = run_err ? '0 : sum_d;
                    rsp_carry_d          = run_err ? 1'b0 : add_carry_i;
                    state_d              = StResp;
                end
            end
            StResp: begin
                ptr_d   = ptr_next[IdxW-1:0];
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            gnt_q       <= '0;
            start_q     <= 1'b0;
            rsp_valid_q <= '0;
            rsp_sum_q   <= '0;
            rsp_carry_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            gnt_q       <= gnt_d;
            start_q     <= start_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign add_start_o = start_q;
    assign add_a_o     = add_a_q;
    assign add_b_o     = add_b_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_sum_o   = rsp_sum_q;
    assign rsp_carry_o = rsp_carry_q;
    assign rsp_err_o   = rsp_err_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Self-checking bench for serial_add_arbiter: directed plan items plus a randomized
// multi-requester phase against an arithmetic/round-robin reference model.
module tb_serial_add_arbiter;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int TO = 32;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic [N-1:0]     req_i = '0;
    logic [N*W-1:0]   req_a_i = '0;
    logic [N*W-1:0]   req_b_i = '0;
    logic [N-1:0]     gnt_o, rsp_valid_o;
    logic [W-1:0]     rsp_sum_o, add_a_o, add_b_o;
    logic             rsp_carry_o, rsp_err_o, busy_o, add_start_o;
    logic             add_sum_bit_i = 1'b0;
    logic             add_carry_i = 1'b0;
    logic             add_done_i = 1'b0;

    serial_add_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
        .gnt_o(gnt_o), .rsp_valid_o(rsp_valid_o), .rsp_sum_o(rsp_sum_o),
        .rsp_carry_o(rsp_carry_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o),
        .add_start_o(add_start_o), .add_a_o(add_a_o), .add_b_o(add_b_o),
        .add_sum_bit_i(add_sum_bit_i), .add_carry_i(add_carry_i), .add_done_i(add_done_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_cnt  = 0;

    // Adder model: 0 = correct, 1 = never signals done, 2 = done with bit early_bit.
    int adder_mode = 0;
    int early_bit  = 4;
    int apos       = -1;
    logic         launched = 1'b0;
    logic [W:0]   aval;
    logic [W-1:0] la, lb;

    always begin
        @(posedge clk_i);
        #1;
        if (launched) begin
            apos = 0;
            aval = {1'b0, la} + {1'b0, lb};
        end else if (apos >= 0) begin
            apos++;
        end
        add_done_i    = 1'b0;
        add_sum_bit_i = 1'b0;
        add_carry_i   = 1'b0;
        if (apos >= 0 && apos < W) begin
            add_sum_bit_i = aval[apos];
            if ((adder_mode == 0 && apos == W - 1) || (adder_mode == 2 && apos == early_bit)) begin
                add_done_i  = 1'b1;
                add_carry_i = aval[W];
                apos        = -1;
            end else begin
                add_carry_i = 1'($urandom);
                if (apos == W - 1) apos = -1;
            end
        end else if (busy_o === 1'b0) begin
            // Idle noise on adder outputs must be ignored.
            add_done_i    = 1'($urandom);
            add_sum_bit_i = 1'($urandom);
            add_carry_i   = 1'($urandom);
        end
        launched = add_start_o;
        la       = add_a_o;
        lb       = add_b_o;
    end

    logic [W-1:0] op_a [N];
    logic [W-1:0] op_b [N];

    task automatic cyc();
        @(posedge clk_i);
        #1;
        cyc_cnt++;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic drive_operands();
        for (int i = 0; i < N; i++) begin
            req_a_i[i*W +: W] = op_a[i];
            req_b_i[i*W +: W] = op_b[i];
        end
    endtask

    // One complete operation from an idle cycle; returns in the idle cycle after RESP.
    task automatic op(input logic [N-1:0] mask, input int wi, input int mode, input string tag);
        logic [W:0]   s;
        logic [N-1:0] oh;
        int           lat;
        bit           bad;
        adder_mode = mode;
        oh = '0;
        oh[wi] = 1'b1;
        s = {1'b0, op_a[wi]} + {1'b0, op_b[wi]};
        drive_operands();
        req_i = mask;
        check({tag, "_idle_busy"}, 64'(busy_o), 64'd0);
        cyc();
        check({tag, "_gnt"}, 64'(gnt_o), 64'(oh));
        check({tag, "_start"}, 64'(add_start_o), 64'd1);
        check({tag, "_opnds"}, {add_a_o, add_b_o}, {op_a[wi], op_b[wi]});
        lat = (mode == 0) ? W + 1 : (mode == 2) ? early_bit + 2 : TO + 2;
        bad = 1'b0;
        for (int n = 1; n < lat; n++) begin
            cyc();
            if (n == 1) req_i = '0;
            if (rsp_valid_o !== '0 || busy_o !== 1'b1) bad = 1'b1;
        end
        check({tag, "_no_early_rsp"}, 64'(bad), 64'd0);
        cyc();
        check({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'(oh));
        if (mode == 0) begin
            check({tag, "_rsp"}, {rsp_sum_o, rsp_carry_o, rsp_err_o}, {s[W-1:0], s[W], 1'b0});
        end else begin
            check({tag, "_rsp_err"}, {rsp_sum_o, rsp_carry_o, rsp_err_o}, {8'h00, 1'b0, 1'b1});
        end
        cyc();
        check({tag, "_busy_fall"}, {busy_o, rsp_valid_o}, 64'd0);
    endtask

    task automatic wait_gnt(output logic [N-1:0] g);
        int waited = 0;
        while (gnt_o === '0 && waited < 40) begin
            cyc();
            waited++;
        end
        g = gnt_o;
    endtask

    initial begin
        logic [N-1:0] g, oh;
        int           last;
        int           order [9] = '{0, 1, 2, 3, 0, 2, 0, 2, 0};
        int           exp_ptr, free_at, rsp_due, rsp_who, w;
        bit           idle_prev, cur_idle, bad;
        logic [N-1:0] prev_req, gnt_prev, exp_g;
        logic [W:0]   rsp_s;

        // Reset state
        cyc();
        cyc();
        check("reset_outputs", {gnt_o, rsp_valid_o, rsp_sum_o, rsp_carry_o, rsp_err_o, busy_o,
                                add_start_o, add_a_o, add_b_o}, 64'd0);
        rst_i = 1'b0;
        cyc();

        for (int i = 0; i < N; i++) begin
            op_a[i] = 8'($urandom);
            op_b[i] = 8'($urandom);
        end
        op_a[1] = 8'hAA; op_b[1] = 8'h55;
        op(4'b0010, 1, 0, "single_nocarry");
        op_a[3] = 8'hF4; op_b[3] = 8'h2F;
        op(4'b1000, 3, 0, "single_carry");

        op_a[2] = 8'h80; op_b[2] = 8'h80;
        op(4'b0100, 2, 1, "timeout");
        op_a[0] = 8'h7F; op_b[0] = 8'h01;
        op(4'b0001, 0, 0, "after_timeout");

        op_a[1] = 8'h0F; op_b[1] = 8'h01;
        op(4'b0010, 1, 2, "early_done");

        // Fairness with continuous requests from reset release
        adder_mode = 0;
        rst_i = 1'b1;
        cyc();
        cyc();
        rst_i = 1'b0;
        req_i = 4'hF;
        last  = 0;
        for (int k = 0; k < 9; k++) begin
            wait_gnt(g);
            oh = '0;
            oh[order[k]] = 1'b1;
            check($sformatf("fair_gnt%0d", k), 64'(g), 64'(oh));
            if (k > 0) check($sformatf("fair_spacing%0d", k), 64'(cyc_cnt - last), 64'(W + 3));
            last = cyc_cnt;
            cyc();
            if (k == 4) req_i = 4'b0101;
        end
        req_i = '0;
        for (int k = 0; k < 14; k++) cyc();

        // Reset mid-operation
        op_a[1] = 8'h12; op_b[1] = 8'h34;
        op(4'b0010, 1, 0, "pre_rst");
        req_i = 4'b0001;
        cyc();
        check("midrst_gnt", 64'(gnt_o), 64'b0001);
        cyc();
        req_i = '0;
        cyc();
        cyc();
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        check("midrst_outputs", {gnt_o, rsp_valid_o, rsp_sum_o, rsp_carry_o, rsp_err_o, busy_o,
                                 add_start_o, add_a_o, add_b_o}, 64'd0);
        bad = 1'b0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            if (rsp_valid_o !== '0 || busy_o !== 1'b0) bad = 1'b1;
        end
        check("midrst_no_rsp", 64'(bad), 64'd0);
        op_a[1] = 8'h99; op_b[1] = 8'h99;
        op_a[3] = 8'h01; op_b[3] = 8'h02;
        op(4'b1010, 1, 0, "post_rst_ptr0");

        // Randomized multi-requester traffic
        adder_mode = 0;
        exp_ptr   = 2;
        free_at   = 0;
        rsp_due   = -1;
        rsp_who   = 0;
        rsp_s     = '0;
        idle_prev = 1'b1;
        prev_req  = '0;
        gnt_prev  = '0;
        for (int c = 0; c < 400; c++) begin
            exp_g = '0;
            if (idle_prev && prev_req != '0) begin
                w        = rr(prev_req, exp_ptr);
                exp_g[w] = 1'b1;
                rsp_due  = c + W + 1;
                rsp_who  = w;
                rsp_s    = {1'b0, op_a[w]} + {1'b0, op_b[w]};
                free_at  = c + W + 2;
            end
            check("rnd_gnt", 64'(gnt_o), 64'(exp_g));
            if (c == rsp_due) begin
                oh = '0;
                oh[rsp_who] = 1'b1;
                check("rnd_rsp", {rsp_valid_o, rsp_sum_o, rsp_carry_o, rsp_err_o},
                      {oh, rsp_s[W-1:0], rsp_s[W], 1'b0});
                exp_ptr = (rsp_who + 1) % N;
            end else begin
                check("rnd_no_rsp", 64'(rsp_valid_o), 64'd0);
            end
            cur_idle = (c >= free_at);
            for (int i = 0; i < N; i++) begin
                if (gnt_prev[i]) begin
                    req_i[i] = 1'b0;
                end else if (!req_i[i] && $urandom_range(0, 3) == 0) begin
                    op_a[i]  = 8'($urandom);
                    op_b[i]  = 8'($urandom);
                    req_i[i] = 1'b1;
                end
            end
            drive_operands();
            prev_req  = req_i;
            idle_prev = cur_idle;
            gnt_prev  = exp_g;
            cyc();
        end
        req_i = '0;
        for (int k = 0; k < 14; k++) cyc();
        check("final_idle", 64'(busy_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_add_arbiter.md
# serial_add_arbiter

Round-robin arbiter and sequencer that shares one bit-serial 8-bit adder among four requesters. It latches the winning requester's operands, launches the adder, and deserialises the LSB-first sum stream into a parallel result. It returns the result, the carry and an error flag to the granted requester. It sits between the requesting client blocks and the serial adder, and owns the adder's start/operand inputs exclusively.

## Interface
- N_REQ, 4: number of requesters; fixed at 4 for this revision.
- WIDTH, 8: operand and sum width, in bits.
- TIMEOUT, 32: maximum number of RUN cycles allowed without `add_done` before an error abort.

- clk  in  1  single system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester request level.
- req_a  in  N_REQ*WIDTH  packed operand A; requester i is bits [i*WIDTH +: WIDTH].
- req_b  in  N_REQ*WIDTH  packed operand B; same packing as `req_a`.
- gnt  out  N_REQ  one-hot, one-cycle pulse; marks the cycle the operands are launched.
- rsp_valid  out  N_REQ  one-hot, one-cycle pulse; result is valid for requester i.
- rsp_sum  out  WIDTH  sum result; valid only while `rsp_valid` is nonzero.
- rsp_carry  out  1  final carry; valid only while `rsp_valid` is nonzero.
- rsp_err  out  1  error flag (timeout or bit-count mismatch); valid only with `rsp_valid`.
- busy  out  1  high in every state except IDLE.
- add_start  out  1  one-cycle launch pulse to the adder.
- add_a, add_b  out  WIDTH  operands to the adder; held stable from launch until return to IDLE.
- add_sum_bit  in  1  serial sum bit from the adder, LSB first.
- add_carry  in  1  adder carry; sampled only in the cycle where `add_done` is high.
- add_done  in  1  adder completion; high in the same cycle as the MSB sum bit.

## Operation
- **Adder contract.** After `add_start` in cycle L, the adder presents bit 0 in cycle L+1 and bit k in cycle L+1+k. `add_done` is high together with bit WIDTH-1.
- **States.** IDLE → LAUNCH → RUN → RESP → IDLE.
- **IDLE.**
  - If `req` is nonzero, pick the winner i round-robin: the first set bit starting at `ptr`, wrapping upward.
  - Latch `req_a[i]` and `req_b[i]` into `add_a` / `add_b`, then go to LAUNCH.
  - If `req` is zero, stay in IDLE.
- **LAUNCH.** `gnt[i]` = 1 and `add_start` = 1 for exactly this cycle; clear the bit counter and the timeout counter; go to RUN.
- **RUN.** Every cycle:
  - Shift the sum register right and insert `add_sum_bit` at the MSB.
  - Increment the bit counter and the timeout counter.
  - If `add_done` is high: capture `add_carry`; err = (bits captured including this cycle ≠ WIDTH); go to RESP.
  - Else if the timeout counter reaches TIMEOUT: err = 1; go to RESP.
- **RESP.**
  - `rsp_valid[i]` = 1 for exactly this cycle.
  - `rsp_sum` = captured register; `rsp_carry` = captured carry; `rsp_err` = err.
  - On any error, `rsp_sum` and `rsp_carry` are forced to 0.
  - `ptr` ← (i+1) mod N_REQ; go to IDLE.
- **Requester rules.**
  - Hold `req` and the operands until `gnt` is seen.
  - Drop `req` in the cycle after `gnt` unless another operation is wanted.
  - `req` still high in the IDLE cycle after RESP is a new request.
- **Ignored inputs.** `add_done`, `add_sum_bit` and `add_carry` are ignored outside RUN.
- **Reset.**
  - `rst` forces state to IDLE and `ptr` to 0.
  - All outputs are 0: `gnt`, `rsp_valid`, `rsp_sum`, `rsp_carry`, `rsp_err`, `busy`, `add_start`, `add_a`, `add_b`.
  - Reset mid-operation discards the in-flight result; no `rsp_valid` is issued for it.

## Timing
- All outputs are registered.
- Request arbitrated in IDLE cycle T:
  - `gnt` and `add_start` in T+1.
  - Sum bits sampled in T+2 … T+1+WIDTH.
  - `rsp_valid` in T+2+WIDTH (T+10 for WIDTH = 8).
  - Earliest next arbitration in T+3+WIDTH; earliest next `gnt` in T+4+WIDTH.
- Throughput: one operation per WIDTH+3 cycles (11 cycles for WIDTH = 8) with continuous requests.
- Timeout abort: `rsp_valid` with `rsp_err` = 1 in T+3+TIMEOUT.
- `busy` rises in T+1 and falls in the cycle after RESP.

## Test plan
- **Single request, no carry.** Requester 1 requests with A=0xAA, B=0x55; adder model correct. Required: `gnt` = 0010 at T+1; `rsp_valid` = 0010 at T+10 with `rsp_sum` = 0xFF, `rsp_carry` = 0, `rsp_err` = 0.
- **Single request, with carry.** Requester 3 requests with A=0xF4, B=0x2F. Required: `rsp_sum` = 0x23, `rsp_carry` = 1, `rsp_err` = 0.
- **Fairness.** All four `req` bits held high from reset release. Required: grants in order 0, 1, 2, 3, 0 with 11-cycle spacing. Then only requesters 0 and 2 held high: grants alternate 0, 2, 0, 2.
- **Timeout.** Adder model never asserts `add_done`. Required: `rsp_valid` with `rsp_err` = 1, `rsp_sum` = 0, `rsp_carry` = 0 exactly TIMEOUT+2 cycles after `gnt`; `busy` then falls and the next request is served normally.
- **Early done.** Adder model asserts `add_done` with the 5th sum bit. Required: `rsp_err` = 1 and `rsp_sum` = 0.
- **Reset mid-operation.** `rst` pulsed for one cycle during RUN. Required: no `rsp_valid` for that operation, all outputs 0 the cycle after reset, and the next request is arbitrated from requester 0.
